// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// The fetch packet pairs an instruction with the word address it came from.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]        instr;
    logic [DEFAULT_ADDR_WIDTH-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory bus plus decode-side instruction handshake for fetch_sequencer.
// Handshake: a head transfers in any cycle with out_valid && out_ready; out_instr/out_pc hold while out_valid && !out_ready.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;

  modport master (
    output mem_addr,
    input  mem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry synchronous FIFO holding fetched packets between memory and decode.
// Flush wins over push in the same cycle; a push on a full FIFO must coincide with a pop.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter type pkt_t = fetch_pkt_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  pkt_t       push_pkt_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output pkt_t       head_o,
  output logic [1:0] count_o
);

  pkt_t       mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full with push and pop together, the write slot is the head being popped.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_pkt_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop_i && !flush_i && count_q == 2'd2));
  assert property (@(posedge clk) disable iff (reset)
    !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, tracks the one-cycle memory read,
// and feeds decode through a two-entry skid FIFO; redirects flush and restart.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  fetch_sequencer_if.master     bus
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } pkt_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count;
  logic [2:0]            occupancy;
  logic                  out_valid;
  logic                  deq;
  logic                  issue;
  pkt_t                  head;
  pkt_t                  push_pkt;

  assign out_valid = (count != 2'd0);
  assign deq       = out_valid && bus.out_ready;

  // Entries that will be held after this cycle if nothing new is issued;
  // capping it at 2 is what keeps the FIFO from overflowing.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, deq};
  assign issue     = fetch_en && !redirect_valid && (occupancy < 3'd2);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_pkt = '{instr: bus.mem_instr, pc: inflight_pc_q};

  // A redirect flushes, which also drops the read returning this cycle.
  fetch_skid_fifo #(
    .pkt_t (pkt_t)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_pkt_i (push_pkt),
    .pop_i      (deq),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .count_o    (count)
  );

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head.instr : NOP_INSTR;
  assign bus.out_pc    = out_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle expected rows plus a handshake scoreboard.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int AW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          rst_b;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;

  logic [31:0] mem_words [128];

  fetch_sequencer_if #(.ADDR_WIDTH(AW)) if_a ();
  fetch_sequencer_if #(.ADDR_WIDTH(AW)) if_b ();

  fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(7'd0)) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (if_a.master)
  );

  fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(7'd126)) u_dut_b (
    .clk            (clk),
    .reset          (rst_b),
    .fetch_en       (1'b1),
    .redirect_valid (1'b0),
    .redirect_addr  (7'd0),
    .bus            (if_b.master)
  );

  // synchronous-read program memories
  always @(posedge clk) if_a.mem_instr <= mem_words[if_a.mem_addr];
  always @(posedge clk) if_b.mem_instr <= mem_words[if_b.mem_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted head must be the next expected PC
  always @(negedge clk) begin
    if (!reset && if_a.out_valid && if_a.out_ready) begin
      logic [7:0] exp_pc;
      if (exp_q.size() != 0) exp_pc = {1'b0, exp_q.pop_front()};
      else                   exp_pc = 8'hFF;
      check_eq("sb_pc", 64'(if_a.out_pc), 64'(exp_pc));
      check_eq("sb_instr", 64'(if_a.out_instr), 64'(mem_words[exp_pc[6:0]]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_head(input string tag, input logic v, input int pc);
    check_eq({tag, "_valid"}, 64'(if_a.out_valid), 64'(v));
    if (v) begin
      check_eq({tag, "_pc"}, 64'(if_a.out_pc), 64'(pc));
      check_eq({tag, "_instr"}, 64'(if_a.out_instr), 64'(mem_words[pc]));
    end
  endtask

  // check this cycle's outputs, apply this cycle's inputs, advance one clock
  task automatic row(input string scen, input logic rdy, input logic fen, input logic redir,
                     input int raddr, input logic v, input int pc, input int addr);
    string tag;
    tag = $sformatf("%s_c%0d", scen, cyc);
    expect_head(tag, v, pc);
    check_eq({tag, "_addr"}, 64'(if_a.mem_addr), 64'(addr));
    if_a.out_ready = rdy;
    fetch_en       = fen;
    redirect_valid = redir;
    redirect_addr  = AW'(raddr);
    tick();
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_valid"}, 64'(if_a.out_valid), 64'(0));
    check_eq({tag, "_instr"}, 64'(if_a.out_instr), 64'(0));
    check_eq({tag, "_pc"}, 64'(if_a.out_pc), 64'(0));
    check_eq({tag, "_addr"}, 64'(if_a.mem_addr), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b_pc   [6] = '{-1, -1, 126, 127, 0, 1};
    int b_addr [6] = '{126, 127, 0, 1, 2, 3};

    for (int a = 0; a < 128; a++) mem_words[a] = 32'hC0DE_0000 | 32'(a);
    mem_words[3] = 32'h0000_0000;

    reset          = 1'b1;
    rst_b          = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    tick();
    tick();
    check_reset_a("rst");

    // stream with a decode stall across cycles 4..9
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    reset = 1'b0;
    cyc   = 0;
    row("s1", 1, 1, 0, 0, 0, 0, 0);
    row("s1", 1, 1, 0, 0, 0, 0, 1);
    row("s1", 1, 1, 0, 0, 1, 0, 2);
    row("s1", 1, 1, 0, 0, 1, 1, 3);
    for (int c = 4; c <= 9; c++) row("s1", 0, 1, 0, 0, 1, 2, 4);
    row("s1", 1, 1, 0, 0, 1, 2, 4);
    row("s1", 1, 1, 0, 0, 1, 3, 5);
    row("s1", 1, 1, 0, 0, 1, 4, 6);
    row("s1", 1, 1, 0, 0, 1, 5, 7);
    check_eq("s1_drained", 64'(exp_q.size()), 64'(0));

    // reset mid-stream: one FIFO entry plus a read in flight
    expect_head("s1_c14", 1, 6);
    check_eq("s1_c14_addr", 64'(if_a.mem_addr), 64'(8));
    reset          = 1'b1;
    if_a.out_ready = 1'b0;
    tick();
    check_reset_a("midrst");

    // restart with cycle-2 latency; fetch_en low in cycle 4 leaves a bubble
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    reset = 1'b0;
    cyc   = 0;
    row("s2", 1, 1, 0, 0, 0, 0, 0);
    row("s2", 1, 1, 0, 0, 0, 0, 1);
    row("s2", 1, 1, 0, 0, 1, 0, 2);
    row("s2", 1, 1, 0, 0, 1, 1, 3);
    row("s2", 1, 0, 0, 0, 1, 2, 4);
    row("s2", 1, 1, 0, 0, 1, 3, 4);
    row("s2", 1, 1, 0, 0, 0, 0, 5);
    row("s2", 1, 1, 0, 0, 1, 4, 6);
    row("s2", 1, 1, 0, 0, 1, 5, 7);
    if_a.out_ready = 1'b0;
    check_eq("s2_drained", 64'(exp_q.size()), 64'(0));
    reset = 1'b1;
    tick();
    tick();

    // redirect to 8 while full, then redirect to 3 together with a dequeue
    exp_q.push_back(7'd0);
    exp_q.push_back(7'd8);
    exp_q.push_back(7'd9);
    exp_q.push_back(7'd10);
    exp_q.push_back(7'd3);
    exp_q.push_back(7'd4);
    reset = 1'b0;
    cyc   = 0;
    row("s3", 1, 1, 0, 0, 0, 0, 0);
    row("s3", 1, 1, 0, 0, 0, 0, 1);
    row("s3", 1, 1, 0, 0, 1, 0, 2);
    row("s3", 0, 1, 0, 0, 1, 1, 3);
    row("s3", 0, 1, 0, 0, 1, 1, 3);
    row("s3", 0, 1, 1, 8, 1, 1, 3);
    row("s3", 1, 1, 0, 0, 0, 0, 8);
    row("s3", 1, 1, 0, 0, 0, 0, 9);
    row("s3", 1, 1, 0, 0, 1, 8, 10);
    row("s3", 1, 1, 0, 0, 1, 9, 11);
    row("s3", 1, 1, 1, 3, 1, 10, 12);
    row("s3", 1, 1, 0, 0, 0, 0, 3);
    row("s3", 1, 1, 0, 0, 0, 0, 4);
    row("s3", 1, 1, 0, 0, 1, 3, 5);
    row("s3", 1, 1, 0, 0, 1, 4, 6);
    if_a.out_ready = 1'b0;
    check_eq("s3_drained", 64'(exp_q.size()), 64'(0));

    // PC wrap from RESET_PC=126 on the second instance
    check_eq("b_rst_valid", 64'(if_b.out_valid), 64'(0));
    check_eq("b_rst_pc", 64'(if_b.out_pc), 64'(0));
    check_eq("b_rst_instr", 64'(if_b.out_instr), 64'(0));
    check_eq("b_rst_addr", 64'(if_b.mem_addr), 64'(126));
    rst_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("b_c%0d_addr", c), 64'(if_b.mem_addr), 64'(b_addr[c]));
      check_eq($sformatf("b_c%0d_valid", c), 64'(if_b.out_valid), 64'(b_pc[c] >= 0));
      if (b_pc[c] >= 0) begin
        check_eq($sformatf("b_c%0d_pc", c), 64'(if_b.out_pc), 64'(b_pc[c]));
        check_eq($sformatf("b_c%0d_instr", c), 64'(if_b.out_instr), 64'(mem_words[b_pc[c]]));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
